// File: rtl/glay_kernel_setup_engine.sv
// glay_kernel_setup_engine
// Turns one descriptor (base address, line count) into a stream of per-line
// fetch requests through a small request FIFO, then counts completion
// responses until the job is done.
// Optional feature: define GLAY_SETUP_TIMEOUT_EN to enable a response
// watchdog in REQ_WAIT that forces completion with setup_error set.
module glay_kernel_setup_engine #(
    parameter int ADDR_W         = 64,
    parameter int CNT_W          = 32,
    parameter int NUM_CHANNELS   = 4,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic              ap_clk,
    input  logic              areset,
    // descriptor
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_base_addr,
    input  logic [CNT_W-1:0]  desc_num_lines,
    // request stream
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [CHAN_W-1:0] req_chan,
    output logic [CNT_W-1:0]  req_id,
    // responses and status
    input  logic              resp_valid,
    output logic              setup_busy,
    output logic              setup_done,
    output logic              setup_error,
    output logic              fifo_setup_signal,
    output logic [CNT_W-1:0]  issued_count,
    output logic [CNT_W-1:0]  resp_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Elaboration-time guard on configurations the datapath cannot support.
    if (NUM_CHANNELS < 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LINE_BYTES < 1 || (LINE_BYTES & (LINE_BYTES - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_cfg
        $error("glay_kernel_setup_engine: unsupported parameter set");
    end

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_REQ_START = 3'd2;
    localparam logic [2:0] S_REQ_BUSY  = 3'd3;
    localparam logic [2:0] S_REQ_WAIT  = 3'd4;
    localparam logic [2:0] S_REQ_DONE  = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CHAN_W-1:0] chan;
        logic [CNT_W-1:0]  id;
    } req_t;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        rst_cnt;

    // job context
    logic [CNT_W-1:0]  job_lines;
    logic [ADDR_W-1:0] gen_addr;
    logic [CHAN_W-1:0] gen_chan;
    logic              resp_ignore;

    // request FIFO
    req_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    req_t              fifo_head;

    logic              accept;
    logic              fifo_full;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              last_wr;
    logic              resp_hit;
    logic              resp_err;
    logic              wd_expire;

    assign accept     = desc_valid && desc_ready;
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_wr    = (state == S_REQ_BUSY) && !fifo_full;
    assign fifo_rd    = req_valid && req_ready;
    assign last_wr    = fifo_wr && (issued_count == job_lines - CNT_W'(1));

    // Responses only count while the job can still expect them; surplus ones
    // (or any in IDLE) flag an error unless they are stragglers from a job
    // that a reset aborted.
    assign resp_hit   = resp_valid && ((state == S_REQ_BUSY) || (state == S_REQ_WAIT)) &&
                        (resp_count != job_lines);
    assign resp_err   = resp_valid && !resp_ignore &&
                        ((state == S_IDLE) || (resp_count == job_lines));

`ifdef GLAY_SETUP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt;

    // Count consecutive response-free cycles spent in REQ_WAIT.
    always_ff @(posedge ap_clk) begin
        if (areset || state != S_REQ_WAIT || resp_valid)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign wd_expire = (state == S_REQ_WAIT) && !resp_valid &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state decode for the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:     if (rst_cnt == 2'd3) state_nxt = S_IDLE;
            S_IDLE:      if (accept) state_nxt = S_REQ_START;
            S_REQ_START: state_nxt = (job_lines == '0) ? S_REQ_DONE : S_REQ_BUSY;
            S_REQ_BUSY:  if (last_wr) state_nxt = S_REQ_WAIT;
            S_REQ_WAIT:  if (resp_count == job_lines || wd_expire) state_nxt = S_REQ_DONE;
            S_REQ_DONE:  state_nxt = S_IDLE;
            default:     state_nxt = S_RESET;
        endcase
    end

    // State register; RESET holds for four cycles after reset release.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state   <= S_RESET;
            rst_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (state == S_RESET) ? rst_cnt + 2'd1 : 2'd0;
        end
    end

    // Job context: latched on acceptance, advanced per written line/response.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            job_lines    <= '0;
            gen_addr     <= '0;
            gen_chan     <= '0;
            issued_count <= '0;
            resp_count   <= '0;
        end else if (accept) begin
            job_lines    <= desc_num_lines;
            gen_addr     <= desc_base_addr;
            gen_chan     <= '0;
            issued_count <= '0;
            resp_count   <= '0;
        end else begin
            if (fifo_wr) begin
                gen_addr     <= gen_addr + ADDR_W'(LINE_BYTES);
                gen_chan     <= (gen_chan == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : gen_chan + CHAN_W'(1);
                issued_count <= issued_count + CNT_W'(1);
            end
            if (resp_hit)
                resp_count <= resp_count + CNT_W'(1);
        end
    end

    // Sticky error plus the "ignore stragglers after reset" flag.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            setup_error <= 1'b0;
            resp_ignore <= 1'b1;
        end else if (accept) begin
            setup_error <= 1'b0;
            resp_ignore <= 1'b0;
        end else if (resp_err || wd_expire) begin
            setup_error <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge ap_clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= '{addr: gen_addr, chan: gen_chan, id: issued_count};
    end

    // FIFO pointers and occupancy; reset flushes any queued requests.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign fifo_head = fifo_mem[rd_ptr];

    assign req_valid         = (fifo_cnt != '0);
    assign req_addr          = fifo_head.addr;
    assign req_chan          = fifo_head.chan;
    assign req_id            = fifo_head.id;

    assign desc_ready        = (state == S_IDLE);
    assign setup_busy        = (state == S_REQ_START) || (state == S_REQ_BUSY) ||
                               (state == S_REQ_WAIT)  || (state == S_REQ_DONE);
    assign setup_done        = (state == S_REQ_DONE);
    assign fifo_setup_signal = (state == S_RESET);

endmodule

// File: tb/tb_glay_kernel_setup_engine.sv
// Self-checking bench for glay_kernel_setup_engine: directed jobs, a
// queue-based model of the expected request stream, and literal pins.
module tb_glay_kernel_setup_engine;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;
    localparam int NCH    = 4;
    localparam int LB     = 64;
    localparam int FD     = 32;
    localparam int TO     = 1024;

    logic              ap_clk;
    logic              areset;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_base_addr;
    logic [CNT_W-1:0]  desc_num_lines;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_chan;
    logic [CNT_W-1:0]  req_id;
    logic              resp_valid;
    logic              setup_busy;
    logic              setup_done;
    logic              setup_error;
    logic              fifo_setup_signal;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  resp_count;

    glay_kernel_setup_engine #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_CHANNELS(NCH),
        .LINE_BYTES(LB), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ap_clk(ap_clk), .areset(areset),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_base_addr(desc_base_addr), .desc_num_lines(desc_num_lines),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_chan(req_chan), .req_id(req_id),
        .resp_valid(resp_valid), .setup_busy(setup_busy), .setup_done(setup_done),
        .setup_error(setup_error), .fifo_setup_signal(fifo_setup_signal),
        .issued_count(issued_count), .resp_count(resp_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected request stream: line i of a job is base + i*LB, channel i mod NCH.
    typedef struct { logic [63:0] addr; int chan; int id; } exp_t;
    exp_t exp_q[$];

    function automatic void model_job(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = base + 64'(i) * 64'(LB);
            e.chan = i % NCH;
            e.id   = i;
            exp_q.push_back(e);
        end
    endfunction

    int          delivered = 0;
    int          done_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr;
    logic [31:0] prev_id;
    logic [63:0] last_addr;
    int          last_chan;

    // Compare process: every handshake against the model, stall stability.
    always @(negedge ap_clk) begin
        if (setup_done) done_cnt++;
        if (prev_stall && !areset) begin
            chk("stall_valid_held", req_valid, 1);
            chk("stall_addr_stable", req_addr, prev_addr);
            chk("stall_id_stable", req_id, prev_id);
        end
        if (req_valid && req_ready && !areset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr 0x%0h id %0d, expected no request", req_addr, req_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("req_addr", req_addr, e.addr);
                chk("req_chan", req_chan, e.chan);
                chk("req_id", req_id, e.id);
                last_addr = req_addr;
                last_chan = req_chan;
                delivered++;
            end
        end
        prev_stall = req_valid && !req_ready && !areset;
        prev_addr  = req_addr;
        prev_id    = req_id;
    end

    task automatic accept(input logic [63:0] base, input int n);
        bit ok = 0;
        @(posedge ap_clk); #1;
        desc_valid = 1'b1; desc_base_addr = base; desc_num_lines = n;
        for (int k = 0; k < 50; k++) begin
            @(negedge ap_clk);
            if (desc_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL desc_accept_timeout: desc_ready low for 50 cycles, expected high");
        end
        @(posedge ap_clk); #1;
        desc_valid = 1'b0;
        if (ok) model_job(base, n);
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge ap_clk); #1;
            lat++;
            if (setup_done) return;
        end
        checks++; errors++;
        $display("FAIL done_timeout: no setup_done within %0d cycles, expected pulse", budget);
    endtask

    task automatic wait_delivered(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge ap_clk); #1;
            if (delivered >= target) return;
        end
        checks++; errors++;
        $display("FAIL deliver_timeout: delivered %0d, expected %0d", delivered, target);
    endtask

    task automatic send_resp(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge ap_clk); #1; resp_valid = 1'b1;
        end
        @(posedge ap_clk); #1; resp_valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, d0, dn, n_setup;
        areset = 1'b1; desc_valid = 1'b0; desc_base_addr = '0; desc_num_lines = '0;
        req_ready = 1'b1; resp_valid = 1'b0;

        // ---- reset state
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_busy", setup_busy, 0);
        chk("rst_done", setup_done, 0);
        chk("rst_error", setup_error, 0);
        chk("rst_fifo_setup", fifo_setup_signal, 1);
        chk("rst_issued", issued_count, 0);
        chk("rst_resp", resp_count, 0);
        @(posedge ap_clk); #1; areset = 1'b0;
        n_setup = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            if (fifo_setup_signal) n_setup++;
        end
        chk("reset_phase_len", n_setup, 4);
        @(negedge ap_clk);
        chk("idle_fifo_setup", fifo_setup_signal, 0);
        chk("idle_desc_ready", desc_ready, 1);

        // ---- basic job: 6 lines from 0x1000
        d0 = done_cnt; dn = delivered;
        accept(64'h1000, 6);
        chk("m_addr0", exp_q[0].addr, 64'h1000);
        chk("m_addr5", exp_q[5].addr, 64'h1140);
        chk("m_chan4", exp_q[4].chan, 0);
        chk("m_chan5", exp_q[5].chan, 1);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ap_clk);
            lat++;
            if (req_valid) break;
        end
        chk("first_req_latency", lat, 3);
        wait_delivered(dn + 6, 50);
        chk("t1_last_addr", last_addr, 64'h1140);
        chk("t1_last_chan", last_chan, 1);
        send_resp(6);
        wait_done(20, lat);
        repeat (3) @(negedge ap_clk);
        #1;
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_error", setup_error, 0);
        chk("t1_issued", issued_count, 6);
        chk("t1_resp", resp_count, 6);

        // ---- stray response in IDLE sets error; counters hold
        send_resp(1);
        @(negedge ap_clk);
        chk("idle_resp_error", setup_error, 1);
        chk("idle_resp_hold", resp_count, 6);
        chk("idle_issued_hold", issued_count, 6);

        // ---- zero-line job; acceptance clears the error
        dn = delivered;
        accept(64'h2000, 0);
        @(negedge ap_clk);
        chk("accept_clears_err", setup_error, 0);
        wait_done(10, lat);
        chk("zero_done_latency", lat + 1, 2);
        chk("zero_issued", issued_count, 0);
        chk("zero_no_requests", delivered - dn, 0);

        // ---- 40 lines with consumer stalled: FIFO fills to 32
        @(posedge ap_clk); #1; req_ready = 1'b0;
        dn = delivered;
        accept(64'h4000, 40);
        chk("m40_size", exp_q.size(), 40);
        chk("m40_addr39", exp_q[39].addr, 64'h49C0);
        chk("m40_chan32", exp_q[32].chan, 0);
        repeat (50) @(negedge ap_clk);
        chk("stall_issued", issued_count, 32);
        chk("stall_req_valid", req_valid, 1);
        @(posedge ap_clk); #1; req_ready = 1'b1;
        wait_delivered(dn + 40, 200);
        chk("t40_delivered", delivered - dn, 40);
        chk("t40_issued", issued_count, 40);
        send_resp(40);
        wait_done(20, lat);

        // ---- address wrap at the top of the address space
        dn = delivered;
        accept(64'hFFFF_FFFF_FFFF_FFC0, 2);
        chk("mw_addr0", exp_q[0].addr, 64'hFFFF_FFFF_FFFF_FFC0);
        chk("mw_addr1", exp_q[1].addr, 64'h0);
        wait_delivered(dn + 2, 20);
        chk("wrap_last_addr", last_addr, 64'h0);
        send_resp(2);
        wait_done(20, lat);

        // ---- reset mid-job after 3 of 10 requests
        d0 = done_cnt; dn = delivered;
        accept(64'h8000, 10);
        wait_delivered(dn + 3, 20);
        @(posedge ap_clk); #1; areset = 1'b1; req_ready = 1'b0;
        @(posedge ap_clk); #1; areset = 1'b0;
        exp_q.delete();
        @(negedge ap_clk);
        chk("abort_req_valid", req_valid, 0);
        chk("abort_fifo_setup", fifo_setup_signal, 1);
        chk("abort_busy", setup_busy, 0);
        chk("abort_issued", issued_count, 0);
        chk("abort_delivered", delivered - dn, 3);
        send_resp(3);
        repeat (6) @(negedge ap_clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("straggler_no_error", setup_error, 0);
        req_ready = 1'b1;
        d0 = done_cnt; dn = delivered;
        accept(64'h9000, 3);
        wait_delivered(dn + 3, 20);
        send_resp(3);
        wait_done(20, lat);
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rejob_done_pulses", done_cnt - d0, 1);
        chk("rejob_error", setup_error, 0);
        chk("rejob_resp", resp_count, 3);

`ifdef GLAY_SETUP_TIMEOUT_EN
        // ---- watchdog: only one of two responses arrives
        dn = delivered;
        accept(64'hA000, 2);
        wait_delivered(dn + 2, 20);
        send_resp(1);
        wait_done(TO + 100, lat);
        chk("timeout_error", setup_error, 1);
        chk("timeout_waited", (lat >= TO), 1);
`endif

        chk("model_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
